// File: rtl/pdh_cmd_initiator.sv
// Command initiator for the PDH GPIO link: sends cmd/data, raises the strobe,
// waits for the responder to echo the command and returns the callback word.
module pdh_cmd_initiator #(
   parameter int SETUP_CYCLES   = 2,
   parameter int RESP_DELAY     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int RST_CYCLES     = 4
) (
   input  logic        clk,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  req_cmd_i,
   input  logic [25:0] req_data_i,
   input  logic        soft_rst_req_i,
   output logic [31:0] gpio_o,
   input  logic [31:0] gpio_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_data_o,
   output logic        resp_err_o,
   output logic        busy_o
);

   localparam int MAX_AB = (SETUP_CYCLES > RESP_DELAY) ? SETUP_CYCLES : RESP_DELAY;
   localparam int MAX_CD = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
   localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      SAMPLE = 3'd3,
      RESP   = 3'd4,
      RRST   = 3'd5
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          pend;
   logic [3:0]    cmd_q;
   logic          ready_q;

   // A soft-reset pulse in the same cycle wins over the request, so the
   // handshake is withdrawn combinationally for that cycle.
   assign req_ready_o = ready_q & ~soft_rst_req_i;
   assign busy_o      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         state        <= IDLE;
         cnt          <= '0;
         pend         <= 1'b0;
         cmd_q        <= 4'd0;
         ready_q      <= 1'b0;
         gpio_o       <= 32'd0;
         resp_valid_o <= 1'b0;
         resp_err_o   <= 1'b0;
         resp_data_o  <= 32'd0;
      end else begin
         pend    <= pend | soft_rst_req_i;
         ready_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pend || soft_rst_req_i) begin
                  state  <= RRST;
                  pend   <= 1'b0;
                  cnt    <= CW'(RST_CYCLES - 1);
                  gpio_o <= 32'h8000_0000;
               end else if (req_valid_i && ready_q) begin
                  state  <= SETUP;
                  cmd_q  <= req_cmd_i;
                  cnt    <= CW'(SETUP_CYCLES - 1);
                  gpio_o <= {2'b00, req_cmd_i, req_data_i};
               end else begin
                  ready_q <= 1'b1;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  state      <= STROBE;
                  cnt        <= CW'(RESP_DELAY - 1);
                  gpio_o[30] <= 1'b1;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            STROBE: begin
               if (cnt == '0) begin
                  state <= SAMPLE;
                  cnt   <= CW'(TIMEOUT_CYCLES - 1);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            SAMPLE: begin
               // The last sampling cycle captures whatever is on the bus as an error word.
               if (gpio_i[31:28] == cmd_q || cnt == '0) begin
                  state        <= RESP;
                  gpio_o[30]   <= 1'b0;
                  resp_valid_o <= 1'b1;
                  resp_data_o  <= gpio_i;
                  resp_err_o   <= (gpio_i[31:28] != cmd_q);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  state        <= IDLE;
                  resp_valid_o <= 1'b0;
                  ready_q      <= ~(pend | soft_rst_req_i);
               end
            end
            RRST: begin
               if (cnt == '0) begin
                  state   <= IDLE;
                  gpio_o  <= 32'd0;
                  ready_q <= ~(pend | soft_rst_req_i);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pdh_cmd_initiator.sv
// Randomized bench for pdh_cmd_initiator with a responder/LED-core model and
// a transaction-level expectation of response timing, data and error flag.
module tb_pdh_cmd_initiator;

   localparam int S  = 2;
   localparam int R  = 4;
   localparam int T  = 64;
   localparam int RC = 4;
   localparam int SR = S + R;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [3:0]  req_cmd_i = 4'd0;
   logic [25:0] req_data_i = 26'd0;
   logic        soft_rst_req_i = 1'b0;
   logic [31:0] gpio_o;
   logic [31:0] gpio_i = 32'd0;
   logic        resp_valid_o;
   logic        resp_ready_i = 1'b0;
   logic [31:0] resp_data_o;
   logic        resp_err_o;
   logic        busy_o;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] led_model = 8'd0;

   pdh_cmd_initiator #(
      .SETUP_CYCLES(S), .RESP_DELAY(R), .TIMEOUT_CYCLES(T), .RST_CYCLES(RC)
   ) dut (
      .clk(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_cmd_i(req_cmd_i), .req_data_i(req_data_i),
      .soft_rst_req_i(soft_rst_req_i),
      .gpio_o(gpio_o), .gpio_i(gpio_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts remote-reset windows and checks the bus returns to 0 with ready high.
   task automatic expect_rrst(input string tag);
      int rr;
      rr = 0;
      while (gpio_o === 32'h8000_0000 && rr < 12) begin
         rr++;
         step();
      end
      n_cmp++;
      if (rr !== RC) begin
         n_bad++;
         $display("FAIL %s rrst_len: got %0d want %0d", tag, rr, RC);
      end
      n_cmp++;
      if (gpio_o !== 32'd0 || req_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL %s after_rrst: gpio %h ready %b want 00000000 1", tag, gpio_o, req_ready_o);
      end
   endtask

   // One full transaction; the responder shows echo_w from window echo_at on
   // (echo_at < 0 means never) and idle_w before that.
   task automatic do_txn(input string tag, input logic [3:0] cmd, input logic [25:0] data,
                         input int echo_at, input logic [31:0] echo_w, input logic [31:0] idle_w,
                         input int hold, input int soft_at);
      int exp_n, n, waitc, strobe_cnt, first;
      logic [31:0] exp_data;
      logic exp_err, seen, bad_body, bad_hold;

      if (echo_at >= 0 && echo_at <= SR + T - 1) begin
         first    = (echo_at < SR) ? SR : echo_at;
         exp_n    = first + 1;
         exp_data = echo_w;
         exp_err  = 1'b0;
      end else begin
         exp_n    = SR + T;
         exp_data = idle_w;
         exp_err  = 1'b1;
      end

      waitc = 0;
      while (req_ready_o !== 1'b1 && waitc < 200) begin
         step();
         waitc++;
      end
      n_cmp++;
      if (waitc >= 200) begin
         n_bad++;
         $display("FAIL %s ready_wait: got timeout want req_ready_o=1", tag);
      end

      req_valid_i  = 1'b1;
      req_cmd_i    = cmd;
      req_data_i   = data;
      gpio_i       = idle_w;
      resp_ready_i = (hold == 0);
      step();
      req_valid_i = 1'b0;
      n = 0;

      n_cmp++;
      if (gpio_o !== {2'b00, cmd, data} || busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL %s setup_word: gpio %h busy %b want %h 1", tag, gpio_o, busy_o, {2'b00, cmd, data});
      end

      strobe_cnt = 0;
      seen = 1'b0;
      bad_body = 1'b0;
      while (!seen && n < SR + T + 5) begin
         gpio_i = (echo_at >= 0 && n >= echo_at) ? echo_w : idle_w;
         soft_rst_req_i = (n == soft_at);
         if (gpio_o[29:0] !== {cmd, data} || gpio_o[31] !== 1'b0) bad_body = 1'b1;
         if (resp_valid_o === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (gpio_o[30] === 1'b1) begin
               strobe_cnt++;
               if (cmd == 4'd1) led_model = gpio_o[7:0];
            end
            step();
            n++;
         end
      end
      soft_rst_req_i = 1'b0;

      n_cmp++;
      if (n !== exp_n) begin
         n_bad++;
         $display("FAIL %s latency: got %0d want %0d edges after accept", tag, n, exp_n);
      end
      n_cmp++;
      if (resp_data_o !== exp_data || resp_err_o !== exp_err) begin
         n_bad++;
         $display("FAIL %s resp: got %h err %b want %h err %b", tag, resp_data_o, resp_err_o, exp_data, exp_err);
      end
      n_cmp++;
      if (strobe_cnt !== exp_n - S || gpio_o[30] !== 1'b0 || bad_body) begin
         n_bad++;
         $display("FAIL %s strobe: got %0d cycles (now %b, body_bad %b) want %0d", tag, strobe_cnt, gpio_o[30], bad_body, exp_n - S);
      end

      bad_hold = 1'b0;
      for (int h = 0; h < hold; h++) begin
         if (resp_valid_o !== 1'b1 || resp_data_o !== exp_data || resp_err_o !== exp_err ||
             gpio_o !== {2'b00, cmd, data} || req_ready_o !== 1'b0 || busy_o !== 1'b1) bad_hold = 1'b1;
         step();
      end
      if (hold > 0) begin
         n_cmp++;
         if (bad_hold || resp_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s backpressure: got unstable (valid %b) want stable for %0d cycles", tag, resp_valid_o, hold);
         end
      end
      resp_ready_i = 1'b1;
      step();
      resp_ready_i = 1'b0;

      n_cmp++;
      if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || gpio_o !== {2'b00, cmd, data} ||
          req_ready_o !== (soft_at < 0)) begin
         n_bad++;
         $display("FAIL %s done: valid %b busy %b gpio %h ready %b want 0 0 %h %b",
                  tag, resp_valid_o, busy_o, gpio_o, req_ready_o, {2'b00, cmd, data}, soft_at < 0);
      end
      if (soft_at >= 0) begin
         step();
         expect_rrst(tag);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (gpio_o !== 32'd0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || busy_o !== 1'b0 ||
          resp_data_o !== 32'd0 || resp_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: gpio %h valid %b ready %b busy %b data %h err %b want all 0",
                  gpio_o, resp_valid_o, req_ready_o, busy_o, resp_data_o, resp_err_o);
      end
      rst_ni = 1'b1;
      step();
      n_cmp++;
      if (req_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release_ready: got %b want 1", req_ready_o);
      end
   endtask

   task automatic test_set_led();
      led_model = 8'd0;
      do_txn("set_led", 4'd1, 26'h0A5, S + 2, 32'h1000_00A5, 32'h0000_0000, 0, -1);
      n_cmp++;
      if (led_model !== 8'hA5) begin
         n_bad++;
         $display("FAIL set_led led: got %h want a5", led_model);
      end
   endtask

   task automatic test_timeout();
      do_txn("timeout", 4'd2, 26'h123_4567, -1, 32'hFFFF_FFFF, 32'h0000_0000, 0, -1);
   endtask

   task automatic test_backpressure();
      do_txn("backpressure", 4'd4, 26'h2AA_AAAA, 7, 32'h4BCD_1234, 32'h0000_0000, 10, -1);
   endtask

   task automatic test_simultaneous();
      int waitc;
      waitc = 0;
      while (req_ready_o !== 1'b1 && waitc < 200) begin
         step();
         waitc++;
      end
      soft_rst_req_i = 1'b1;
      req_valid_i    = 1'b1;
      req_cmd_i      = 4'd1;
      req_data_i     = 26'h000_003C;
      #1;
      n_cmp++;
      if (req_ready_o !== 1'b0) begin
         n_bad++;
         $display("FAIL simul_ready: got %b want 0", req_ready_o);
      end
      step();
      soft_rst_req_i = 1'b0;
      expect_rrst("simul");
      do_txn("simul_req", 4'd1, 26'h000_003C, SR, 32'h1000_003C, 32'h0000_0000, 0, -1);
   endtask

   task automatic test_mid_reset();
      logic bad;
      req_valid_i = 1'b1;
      req_cmd_i   = 4'd4;
      req_data_i  = 26'h155_5555;
      gpio_i      = 32'h4000_0001;
      step();
      req_valid_i = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (gpio_o[30] !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reset_strobe: got %b want 1", gpio_o[30]);
      end
      rst_ni = 1'b0;
      step();
      n_cmp++;
      if (gpio_o !== 32'd0 || resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset_abort: gpio %h valid %b busy %b want 0 0 0", gpio_o, resp_valid_o, busy_o);
      end
      rst_ni = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         step();
         if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
         n_bad++;
         $display("FAIL mid_reset_no_resp: got response/busy want none");
      end
      do_txn("after_reset", 4'd2, 26'h000_0BEE, SR + 3, 32'h2000_0BEE, 32'h0000_0000, 1, -1);
   endtask

   task automatic test_random();
      logic [3:0]  cmd;
      logic [25:0] data;
      logic [31:0] echo_w, idle_w;
      int echo_at, hold, soft_at;
      for (int i = 0; i < 16; i++) begin
         cmd     = 4'($urandom_range(0, 15));
         data    = 26'($urandom);
         echo_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 80));
         echo_w  = {cmd, 28'($urandom)};
         idle_w  = {cmd ^ 4'h8, 28'($urandom)};
         hold    = int'($urandom_range(0, 3));
         soft_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SR)) : -1;
         do_txn($sformatf("rand%0d", i), cmd, data, echo_at, echo_w, idle_w, hold, soft_at);
      end
   endtask

   initial begin
      test_reset();
      test_set_led();
      test_timeout();
      test_backpressure();
      test_simultaneous();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
